// File: rtl/pkt_hdr_edit_pkg.sv
// ---------------------------------------------------------------------------
// pkt_hdr_edit_pkg : shared beat-state encoding and header field offsets
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package pkt_hdr_edit_pkg;

  typedef enum logic [1:0] {
    IDLE_S  = 2'd0,
    BEAT1_S = 2'd1,
    BEAT2_S = 2'd2,
    BEAT3_S = 2'd3
  } phe_state_e;

  localparam int SEQ_MSB = 127;
  localparam int SEQ_LSB = 112;
  localparam int TS_MSB  = 111;
  localparam int TS_LSB  = 80;
  localparam int SEQ_W   = SEQ_MSB - SEQ_LSB + 1;

  localparam logic [1:0] EDIT_BEAT = 2'd2;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/pkt_hdr_edit_seq_table.sv
// ---------------------------------------------------------------------------
// phe_seq_table : per-flow 16-bit sequence counters, clear-wins increment
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module phe_seq_table
  import pkt_hdr_edit_pkg::*;
#(
  parameter int FLOW_NUM = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [2:0]          rd_idx,
  output logic [SEQ_W-1:0]    rd_seq,
  input  logic                inc_en,
  input  logic [2:0]          inc_idx,
  input  logic [FLOW_NUM-1:0] clr
);

  logic [SEQ_W-1:0] seq_all [FLOW_NUM];

  for (genvar i = 0; i < FLOW_NUM; i++) begin : g_flow
    logic [SEQ_W-1:0] seq_q;
    logic [SEQ_W-1:0] seq_d;

    always_comb begin
      seq_d = seq_q;
      if (clr[i]) begin
        seq_d = '0;
      end else if (inc_en && (inc_idx == 3'(i))) begin
        seq_d = seq_q + 16'd1;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        seq_q <= '0;
      end else begin
        seq_q <= seq_d;
      end
    end

    assign seq_all[i] = seq_q;
  end

  // A clear in the stamping cycle must already show up in the stamp.
  assign rd_seq = clr[rd_idx] ? '0 : seq_all[rd_idx];

endmodule

`default_nettype wire

// File: rtl/pkt_hdr_edit.sv
// ---------------------------------------------------------------------------
// pkt_hdr_edit : stamps sequence/timestamp into beat 2 of 4-beat headers
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module pkt_hdr_edit
  import pkt_hdr_edit_pkg::*;
#(
  parameter     PLATFORM = "xilinx",
  parameter int FLOW_NUM = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [2:0]          in_phe_flow_id,
  input  logic [31:0]         in_phe_local_time,
  input  logic                in_phe_ts_en,
  input  logic [FLOW_NUM-1:0] in_phe_seq_clr,
  input  logic [127:0]        in_phe_pkt_hdr,
  input  logic                in_phe_pkt_hdr_wr,
  output logic [127:0]        out_phe_pkt_hdr,
  output logic                out_phe_pkt_hdr_wr,
  output logic                out_phe_pkt_hdr_head,
  output logic                out_phe_pkt_hdr_tail,
  output logic                out_phe_abort,
  output logic [31:0]         out_phe_pkt_cnt,
  output logic [15:0]         out_phe_abort_cnt
);

  if (PLATFORM == "") begin : g_platform_unset
  end

  phe_state_e       state_q, state_d;
  logic [2:0]       flow_q, flow_d;
  logic [31:0]      ts_q, ts_d;
  logic [127:0]     hdr_q, hdr_d;
  logic             wr_q, wr_d;
  logic             head_q, head_d;
  logic             tail_q, tail_d;
  logic             abort_q, abort_d;
  logic [31:0]      pkt_cnt_q, pkt_cnt_d;
  logic [15:0]      abort_cnt_q, abort_cnt_d;
  logic             seq_inc;
  logic [SEQ_W-1:0] seq_rd;

  phe_seq_table #(
    .FLOW_NUM (FLOW_NUM)
  ) u_seq (
    .clk     (clk),
    .rst_n   (rst_n),
    .rd_idx  (flow_q),
    .rd_seq  (seq_rd),
    .inc_en  (seq_inc),
    .inc_idx (flow_q),
    .clr     (in_phe_seq_clr)
  );

  always_comb begin
    state_d     = state_q;
    flow_d      = flow_q;
    ts_d        = ts_q;
    hdr_d       = '0;
    wr_d        = 1'b0;
    head_d      = 1'b0;
    tail_d      = 1'b0;
    abort_d     = 1'b0;
    pkt_cnt_d   = pkt_cnt_q;
    abort_cnt_d = abort_cnt_q;
    seq_inc     = 1'b0;

    if (in_phe_pkt_hdr_wr) begin
      wr_d    = 1'b1;
      hdr_d   = in_phe_pkt_hdr;
      head_d  = (state_q == IDLE_S);
      tail_d  = (state_q == BEAT3_S);
      // The state doubles as the beat index; BEAT3 wraps back to IDLE.
      state_d = phe_state_e'(state_q + 2'd1);
      case (state_q)
        IDLE_S: begin
          flow_d = in_phe_flow_id;
          ts_d   = in_phe_local_time;
        end
        BEAT3_S: begin
          seq_inc   = 1'b1;
          pkt_cnt_d = pkt_cnt_q + 32'd1;
        end
        default: ;
      endcase
      if (state_q == EDIT_BEAT) begin
        hdr_d[SEQ_MSB:SEQ_LSB] = seq_rd;
        if (in_phe_ts_en) begin
          hdr_d[TS_MSB:TS_LSB] = ts_q;
        end
      end
    end else if (state_q != IDLE_S) begin
      abort_d     = 1'b1;
      abort_cnt_d = sat_inc16(abort_cnt_q);
      state_d     = IDLE_S;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE_S;
      flow_q      <= '0;
      ts_q        <= '0;
      hdr_q       <= '0;
      wr_q        <= 1'b0;
      head_q      <= 1'b0;
      tail_q      <= 1'b0;
      abort_q     <= 1'b0;
      pkt_cnt_q   <= '0;
      abort_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      flow_q      <= flow_d;
      ts_q        <= ts_d;
      hdr_q       <= hdr_d;
      wr_q        <= wr_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      abort_q     <= abort_d;
      pkt_cnt_q   <= pkt_cnt_d;
      abort_cnt_q <= abort_cnt_d;
    end
  end

  assign out_phe_pkt_hdr      = hdr_q;
  assign out_phe_pkt_hdr_wr   = wr_q;
  assign out_phe_pkt_hdr_head = head_q;
  assign out_phe_pkt_hdr_tail = tail_q;
  assign out_phe_abort        = abort_q;
  assign out_phe_pkt_cnt      = pkt_cnt_q;
  assign out_phe_abort_cnt    = abort_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_pkt_hdr_edit.sv
// ---------------------------------------------------------------------------
// tb_pkt_hdr_edit : directed stimulus with a queue-based output scoreboard
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_pkt_hdr_edit;

  typedef struct packed {
    logic [127:0] hdr;
    logic         head;
    logic         tail;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [2:0]   in_flow;
  logic [31:0]  in_time;
  logic         in_ts_en;
  logic [7:0]   in_clr;
  logic [127:0] in_hdr;
  logic         in_wr;
  logic [127:0] out_hdr;
  logic         out_wr;
  logic         out_head;
  logic         out_tail;
  logic         out_abort;
  logic [31:0]  out_pkt_cnt;
  logic [15:0]  out_abort_cnt;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  int   exp_abort = 0;

  always #5 clk = ~clk;

  pkt_hdr_edit #(
    .PLATFORM ("xilinx"),
    .FLOW_NUM (8)
  ) u_dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .in_phe_flow_id       (in_flow),
    .in_phe_local_time    (in_time),
    .in_phe_ts_en         (in_ts_en),
    .in_phe_seq_clr       (in_clr),
    .in_phe_pkt_hdr       (in_hdr),
    .in_phe_pkt_hdr_wr    (in_wr),
    .out_phe_pkt_hdr      (out_hdr),
    .out_phe_pkt_hdr_wr   (out_wr),
    .out_phe_pkt_hdr_head (out_head),
    .out_phe_pkt_hdr_tail (out_tail),
    .out_phe_abort        (out_abort),
    .out_phe_pkt_cnt      (out_pkt_cnt),
    .out_phe_abort_cnt    (out_abort_cnt)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] beat_data(input logic [31:0] base, input int k);
    logic [31:0] a;
    a = base + 32'(k);
    return {a, ~a, a ^ 32'hC3C3_C3C3, 32'(k)};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      cyc();
      in_wr  = 1'b0;
      in_hdr = '0;
      in_clr = '0;
    end
  endtask

  // Drives nbeats contiguous beats; wr is left high for the caller to drop.
  task automatic send_pkt(input logic [2:0] flow, input logic [31:0] tm, input logic ts_en,
                          input logic [31:0] base, input logic [15:0] stamp,
                          input int nbeats, input logic [7:0] clr_last, input logic want_abort);
    exp_t e;
    for (int k = 0; k < nbeats; k++) begin
      cyc();
      in_wr    = 1'b1;
      in_hdr   = beat_data(base, k);
      in_flow  = (k == 0) ? flow : ~flow;
      in_time  = (k == 0) ? tm : tm + 32'd99;
      in_ts_en = (k == 2) ? ts_en : ~ts_en;
      in_clr   = (k == 3) ? clr_last : 8'h00;
      e.hdr    = beat_data(base, k);
      if (k == 2) begin
        e.hdr[127:112] = stamp;
        if (ts_en) e.hdr[111:80] = tm;
      end
      e.head = (k == 0);
      e.tail = (k == 3);
      sb.push_back(e);
    end
    if (want_abort) exp_abort++;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (out_wr) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: got %0h expected no beat", out_hdr);
        end else begin
          e = sb.pop_front();
          chk("beat", {out_hdr, out_head, out_tail}, {e.hdr, e.head, e.tail});
        end
      end else begin
        chk("idle_out", {out_hdr, out_head, out_tail}, '0);
      end
      if (out_abort) begin
        checks++;
        if (exp_abort > 0) begin
          exp_abort--;
        end else begin
          errors++;
          $display("FAIL unexpected_abort: got 1 expected 0");
        end
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL timeout: got no end expected finish");
    $fatal(1, "timeout");
  end

  initial begin : stim
    rst_n    = 1'b0;
    in_flow  = '0;
    in_time  = '0;
    in_ts_en = 1'b0;
    in_clr   = '0;
    in_hdr   = '0;
    in_wr    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_outputs", {out_hdr, out_wr, out_head, out_tail, out_abort}, '0);
    chk("rst_pkt_cnt", 128'(out_pkt_cnt), 128'd0);
    chk("rst_abort_cnt", 128'(out_abort_cnt), 128'd0);
    rst_n = 1'b1;
    idle(2);

    // Single packet, flow 3, timestamp inserted
    send_pkt(3'd3, 32'h1234_5678, 1'b1, 32'hA000_0000, 16'h0000, 4, 8'h00, 1'b0);
    idle(3);
    chk("pkt_cnt_1", 128'(out_pkt_cnt), 128'd1);

    // Three back-to-back packets on flow 0, timestamp disabled
    send_pkt(3'd0, 32'h0000_1111, 1'b0, 32'hB000_0000, 16'h0000, 4, 8'h00, 1'b0);
    send_pkt(3'd0, 32'h0000_2222, 1'b0, 32'hB100_0000, 16'h0001, 4, 8'h00, 1'b0);
    send_pkt(3'd0, 32'h0000_3333, 1'b0, 32'hB200_0000, 16'h0002, 4, 8'h00, 1'b0);
    send_pkt(3'd3, 32'hCAFE_0001, 1'b1, 32'hB300_0000, 16'h0001, 4, 8'h00, 1'b0);
    idle(3);
    chk("pkt_cnt_5", 128'(out_pkt_cnt), 128'd5);

    // Sequence wrap on flow 5
    force u_dut.u_seq.g_flow[5].seq_q = 16'hFFFF;
    idle(2);
    release u_dut.u_seq.g_flow[5].seq_q;
    idle(1);
    send_pkt(3'd5, 32'h5555_0000, 1'b1, 32'hC000_0000, 16'hFFFF, 4, 8'h00, 1'b0);
    send_pkt(3'd5, 32'h5555_0001, 1'b1, 32'hC100_0000, 16'h0000, 4, 8'h00, 1'b0);
    idle(3);
    chk("pkt_cnt_7", 128'(out_pkt_cnt), 128'd7);

    // Truncation after 2 beats, then after 3 beats (beat 2 stamped)
    send_pkt(3'd6, 32'h6666_0000, 1'b1, 32'hD000_0000, 16'h0000, 2, 8'h00, 1'b1);
    idle(3);
    chk("abort_cnt_1", 128'(out_abort_cnt), 128'd1);
    chk("pkt_cnt_abort", 128'(out_pkt_cnt), 128'd7);
    send_pkt(3'd6, 32'h6666_0001, 1'b1, 32'hD100_0000, 16'h0000, 4, 8'h00, 1'b0);
    send_pkt(3'd6, 32'h6666_0002, 1'b0, 32'hD200_0000, 16'h0001, 3, 8'h00, 1'b1);
    idle(3);
    chk("abort_cnt_2", 128'(out_abort_cnt), 128'd2);
    send_pkt(3'd6, 32'h6666_0003, 1'b0, 32'hD300_0000, 16'h0001, 4, 8'h00, 1'b0);
    idle(3);
    chk("pkt_cnt_9", 128'(out_pkt_cnt), 128'd9);

    // Clear coinciding with the flow-2 increment wins
    send_pkt(3'd2, 32'h2222_0000, 1'b1, 32'hE000_0000, 16'h0000, 4, 8'h00, 1'b0);
    send_pkt(3'd2, 32'h2222_0001, 1'b1, 32'hE100_0000, 16'h0001, 4, 8'h04, 1'b0);
    send_pkt(3'd2, 32'h2222_0002, 1'b1, 32'hE200_0000, 16'h0000, 4, 8'h00, 1'b0);
    idle(3);
    chk("pkt_cnt_12", 128'(out_pkt_cnt), 128'd12);

    // Reset during BEAT2: outputs clear at once, no abort pulse
    send_pkt(3'd0, 32'h7777_0000, 1'b1, 32'hF000_0000, 16'h0003, 2, 8'h00, 1'b0);
    cyc();
    in_hdr = beat_data(32'hF000_0000, 2);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    in_wr = 1'b0;
    #1;
    chk("midrst_outputs", {out_hdr, out_wr, out_head, out_tail, out_abort}, '0);
    chk("midrst_pkt_cnt", 128'(out_pkt_cnt), 128'd0);
    chk("midrst_abort_cnt", 128'(out_abort_cnt), 128'd0);
    cyc();
    rst_n = 1'b1;
    idle(3);
    send_pkt(3'd0, 32'h8888_0000, 1'b1, 32'hF100_0000, 16'h0000, 4, 8'h00, 1'b0);
    idle(3);
    chk("pkt_cnt_after_rst", 128'(out_pkt_cnt), 128'd1);

    idle(2);
    chk("sb_drained", 128'(sb.size()), 128'd0);
    chk("abort_drained", 128'(exp_abort), 128'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pkt_hdr_edit.md
# pkt_hdr_edit

Packet header editor in the traffic-generate path. It sits directly downstream of the header read stage, which emits each selected Ethernet header as 4 consecutive 128-bit beats. The block stamps a per-flow 16-bit sequence number and a 32-bit transmit timestamp into beat 2, marks head and tail beats, and forwards the header to the packet assembly stage. Truncated bursts are detected and flagged, and they never consume a sequence number.

## Interface
Parameters:
- PLATFORM, "xilinx", target vendor tag; no functional effect.
- FLOW_NUM, 8, number of flows and sequence counters; flow ID width is 3.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset. One clock; reset is asynchronous and active-low.
- in_phe_flow_id  in  3  flow index; sampled with the first beat.
- in_phe_local_time  in  32  free-running local time; sampled with the first beat.
- in_phe_ts_en  in  1  1 = insert timestamp; 0 = pass beat 2 bits [111:80] unchanged.
- in_phe_seq_clr  in  8  per-flow synchronous clear of the sequence counter (bit i → flow i).
- in_phe_pkt_hdr  in  128  header beat.
- in_phe_pkt_hdr_wr  in  1  beat valid; a packet is 4 contiguous valid cycles.
- out_phe_pkt_hdr  out  128  edited beat.
- out_phe_pkt_hdr_wr  out  1  output beat valid.
- out_phe_pkt_hdr_head  out  1  high with output beat 0.
- out_phe_pkt_hdr_tail  out  1  high with output beat 3.
- out_phe_abort  out  1  one-cycle pulse when a packet is truncated.
- out_phe_pkt_cnt  out  32  count of completed packets (wraps).
- out_phe_abort_cnt  out  16  count of aborts (saturates at 0xFFFF).

## Operation
- States: IDLE, BEAT1, BEAT2, BEAT3; a 2-bit beat index is implied by the state.
- IDLE:
  - When wr=1, capture the flow ID into flow_r and the local time into ts_r.
  - Forward the beat with head=1.
  - Go to BEAT1.
- BEAT1: when wr=1, forward the beat unchanged and go to BEAT2.
- BEAT2: when wr=1, forward the beat with these edits, then go to BEAT3:
  - bits [127:112] = seq[flow_r];
  - bits [111:80] = ts_r when in_phe_ts_en=1, otherwise unchanged.
  - in_phe_ts_en is sampled in this cycle.
- BEAT3: when wr=1:
  - forward the beat with tail=1;
  - seq[flow_r] += 1 (16-bit wrap, 0xFFFF → 0x0000);
  - pkt_cnt += 1;
  - go to IDLE.
- Truncation: wr=0 in BEAT1, BEAT2 or BEAT3 causes all of the following:
  - out_phe_abort pulses in the next cycle;
  - abort_cnt += 1 (saturating);
  - no sequence increment and no pkt_cnt increment;
  - go to IDLE.
  - Beats already forwarded are not recalled; downstream discards on abort.
- Sequence clear: in_phe_seq_clr[i]=1 sets seq[i]=0. If it coincides with an increment of flow i, the clear wins (result 0).
- Back-to-back: wr=1 in the cycle after a BEAT3 beat is accepted as a new head.

## Timing
- Latency: exactly 1 cycle from input beat to output beat (a single register stage). Output wr mirrors input wr delayed by 1.
- The sequence value stamped into a packet is the counter value before that packet's increment.
- A clear asserted any time up to and including the BEAT2 input cycle affects the stamp of the current packet.
- Reset values:
  - all outputs 0;
  - all seq counters 0;
  - state IDLE;
  - pkt_cnt and abort_cnt 0.
- Reset asserted mid-packet: immediate return to IDLE. The partial packet produces no abort pulse.
- When no beat is forwarded, out_phe_pkt_hdr is driven to 0 and head/tail are 0.

## Structure
- A shared package holds:
  - state encodings (IDLE_S=2'd0 … BEAT3_S=2'd3);
  - field offsets SEQ_MSB=127, SEQ_LSB=112, TS_MSB=111, TS_LSB=80;
  - the edited beat index 2.
- One sub-module: phe_seq_table. It holds FLOW_NUM × 16-bit registers with a read port on flow_r, an increment strobe, and the per-flow clear vector.

## Test plan
- Single packet, flow 3, time 0x1234_5678, ts_en=1, beats A0..A3 → 4 output beats, 1 cycle late, head on beat 0, tail on beat 3; beat 2 [127:112]=0x0000, [111:80]=0x12345678; pkt_cnt=1, seq[3]=1.
- Three packets on flow 0, back-to-back with no idle cycle → stamps 0, 1, 2; ts_en=0 leaves bits [111:80] equal to the input.
- Preload seq[5]=0xFFFF, send a flow-5 packet → stamp 0xFFFF; then the next flow-5 packet stamps 0x0000.
- wr drops after 2 beats → out_phe_abort pulses once, abort_cnt=1, seq and pkt_cnt unchanged; the next full packet carries the same stamp as the truncated one would have.
- seq_clr[2] asserted in the same cycle as the flow-2 BEAT3 increment → seq[2]=0.
- rst_n asserted during BEAT2 → all outputs 0 immediately, no abort pulse; after release, a new packet stamps 0.
